// File: rtl/systolic_host_loader_if.sv
// Bus bundle between the systolic host loader and its environment: job
// configuration, input word stream, memory write ports, result read port,
// controller start/done and the result output stream.
//
// Stream handshake (s_* and m_*): a word transfers on a rising clock edge where
// valid and ready are both high. Once valid is raised, the word is held until it
// transfers. ready depends only on the receiver's state, never on valid.
interface systolic_host_loader_if #(
    parameter int INPUT_WIDTH  = 16,
    parameter int RESULT_WIDTH = 16,
    parameter int ADDR_WIDTH   = 10
);
    logic                    cfg_start;
    logic [ADDR_WIDTH:0]     cfg_len_a;
    logic [ADDR_WIDTH:0]     cfg_len_b;
    logic [ADDR_WIDTH:0]     cfg_len_i;
    logic [ADDR_WIDTH:0]     cfg_len_o;
    logic                    busy;
    logic                    done;
    logic                    s_valid;
    logic                    s_ready;
    logic [INPUT_WIDTH-1:0]  s_data;
    logic [ADDR_WIDTH-1:0]   addrA;
    logic                    enA;
    logic [INPUT_WIDTH-1:0]  dataA;
    logic [ADDR_WIDTH-1:0]   addrB;
    logic                    enB;
    logic [INPUT_WIDTH-1:0]  dataB;
    logic [ADDR_WIDTH-1:0]   addrI;
    logic                    enI;
    logic [INPUT_WIDTH-1:0]  dataI;
    logic [ADDR_WIDTH-1:0]   addrO;
    logic [RESULT_WIDTH-1:0] dataO;
    logic                    ap_start;
    logic                    ap_done;
    logic                    m_valid;
    logic                    m_ready;
    logic [RESULT_WIDTH-1:0] m_data;
    logic                    m_last;
    logic [2:0]              dbg_state;

    // Loader side
    modport master (
        input  cfg_start, cfg_len_a, cfg_len_b, cfg_len_i, cfg_len_o,
        input  s_valid, s_data, dataO, ap_done, m_ready,
        output busy, done, s_ready,
        output addrA, enA, dataA, addrB, enB, dataB, addrI, enI, dataI, addrO,
        output ap_start, m_valid, m_data, m_last, dbg_state
    );

    // Environment side (host, memories, controller, result consumer)
    modport slave (
        output cfg_start, cfg_len_a, cfg_len_b, cfg_len_i, cfg_len_o,
        output s_valid, s_data, dataO, ap_done, m_ready,
        input  busy, done, s_ready,
        input  addrA, enA, dataA, addrB, enB, dataB, addrI, enI, dataI, addrO,
        input  ap_start, m_valid, m_data, m_last, dbg_state
    );
endinterface

// File: rtl/systolic_host_loader.sv
// Host-side job engine for systolic_top: streams A, B and instruction words into
// their memories, kicks the controller, waits for completion, then reads the
// result memory back out onto a backpressured stream via a small output FIFO.
module systolic_host_loader #(
    parameter int INPUT_WIDTH  = 16,
    parameter int RESULT_WIDTH = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int RD_LATENCY   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_host_loader_if.master bus
);
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = RD_LATENCY + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int FCW   = $clog2(DEPTH + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_A = 3'd1;
    localparam logic [2:0] LOAD_B = 3'd2;
    localparam logic [2:0] LOAD_I = 3'd3;
    localparam logic [2:0] START  = 3'd4;
    localparam logic [2:0] WAIT   = 3'd5;
    localparam logic [2:0] DRAIN  = 3'd6;
    localparam logic [2:0] FIN    = 3'd7;

    logic [2:0]              state;
    logic [2:0]              state_next;
    logic [CW-1:0]           len_a;
    logic [CW-1:0]           len_b;
    logic [CW-1:0]           len_i;
    logic [CW-1:0]           len_o;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cur_len;
    logic [CW-1:0]           rd_cnt;
    logic [CW-1:0]           out_cnt;
    logic                    loading;
    logic                    hs;
    logic                    last_word;
    logic [RD_LATENCY-1:0]   pipe;
    logic [FCW-1:0]          fifo_count;
    logic [FCW-1:0]          in_flight;
    logic [FCW:0]            occupancy;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [RESULT_WIDTH-1:0] fifo_mem [DEPTH];
    logic                    issue;
    logic                    capture;
    logic                    pop;
    logic                    fifo_nonempty;

    // Load-phase handshake decode; a phase ends on the handshake of its last word
    always_comb begin
        loading = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_I);
        case (state)
            LOAD_A:  cur_len = len_a;
            LOAD_B:  cur_len = len_b;
            LOAD_I:  cur_len = len_i;
            default: cur_len = '0;
        endcase
        hs        = loading && bus.s_valid;
        last_word = hs && ((cnt + 1'b1) == cur_len);
    end

    // Read issue: reserve a FIFO slot for every read in flight; a pop this cycle frees one
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + FCW'(pipe[i]);
        end
        fifo_nonempty = (fifo_count != '0);
        pop           = fifo_nonempty && bus.m_ready;
        capture       = pipe[RD_LATENCY-1];
        occupancy     = {1'b0, fifo_count} + {1'b0, in_flight} - (FCW+1)'(pop);
        issue         = (state == DRAIN) && (rd_cnt < len_o) &&
                        (occupancy < (FCW+1)'(DEPTH));
    end

    // Next state; empty load phases are skipped without spending a cycle in them
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.cfg_start) begin
                    if (bus.cfg_len_a != '0)      state_next = LOAD_A;
                    else if (bus.cfg_len_b != '0) state_next = LOAD_B;
                    else if (bus.cfg_len_i != '0) state_next = LOAD_I;
                    else                          state_next = START;
                end
            end
            LOAD_A: begin
                if (last_word) begin
                    if (len_b != '0)      state_next = LOAD_B;
                    else if (len_i != '0) state_next = LOAD_I;
                    else                  state_next = START;
                end
            end
            LOAD_B: begin
                if (last_word) state_next = (len_i != '0) ? LOAD_I : START;
            end
            LOAD_I: begin
                if (last_word) state_next = START;
            end
            START: state_next = WAIT;
            WAIT: begin
                if (bus.ap_done) state_next = (len_o == '0) ? FIN : DRAIN;
            end
            DRAIN: begin
                if (pop && (out_cnt == len_o - 1'b1)) state_next = FIN;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, latched job lengths, load counter and registered memory write ports
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len_a     <= '0;
            len_b     <= '0;
            len_i     <= '0;
            len_o     <= '0;
            cnt       <= '0;
            bus.enA   <= 1'b0;
            bus.enB   <= 1'b0;
            bus.enI   <= 1'b0;
            bus.addrA <= '0;
            bus.addrB <= '0;
            bus.addrI <= '0;
            bus.dataA <= '0;
            bus.dataB <= '0;
            bus.dataI <= '0;
        end else begin
            state   <= state_next;
            bus.enA <= hs && (state == LOAD_A);
            bus.enB <= hs && (state == LOAD_B);
            bus.enI <= hs && (state == LOAD_I);
            if ((state == IDLE) && bus.cfg_start) begin
                len_a <= bus.cfg_len_a;
                len_b <= bus.cfg_len_b;
                len_i <= bus.cfg_len_i;
                len_o <= bus.cfg_len_o;
                cnt   <= '0;
            end
            if (hs) begin
                cnt <= last_word ? '0 : cnt + 1'b1;
                case (state)
                    LOAD_A: begin
                        bus.addrA <= cnt[ADDR_WIDTH-1:0];
                        bus.dataA <= bus.s_data;
                    end
                    LOAD_B: begin
                        bus.addrB <= cnt[ADDR_WIDTH-1:0];
                        bus.dataB <= bus.s_data;
                    end
                    LOAD_I: begin
                        bus.addrI <= cnt[ADDR_WIDTH-1:0];
                        bus.dataI <= bus.s_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Result read-back: address issue, latency pipeline and output FIFO.
    // dataO is sampled RD_LATENCY cycles after the issue cycle (addrO updates at the end of it).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.addrO  <= '0;
            rd_cnt     <= '0;
            out_cnt    <= '0;
            pipe       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            pipe <= (pipe << 1) | RD_LATENCY'(issue);
            if ((state == IDLE) && bus.cfg_start) begin
                rd_cnt  <= '0;
                out_cnt <= '0;
            end
            if (issue) begin
                bus.addrO <= rd_cnt[ADDR_WIDTH-1:0];
                rd_cnt    <= rd_cnt + 1'b1;
            end
            if (capture) begin
                fifo_mem[wr_ptr] <= bus.dataO;
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                out_cnt <= out_cnt + 1'b1;
            end
            fifo_count <= fifo_count + FCW'(capture) - FCW'(pop);
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);
    assign bus.s_ready   = loading;
    assign bus.ap_start  = (state == START);
    assign bus.m_valid   = fifo_nonempty;
    assign bus.m_data    = fifo_nonempty ? fifo_mem[rd_ptr] : '0;
    assign bus.m_last    = fifo_nonempty && (out_cnt == len_o - 1'b1);
    assign bus.dbg_state = state;
endmodule
